// File: rtl/norm_row_packer_pkg.sv
// Shared defaults and row types for the normalized-row packer.
// The typedefs describe the default geometry.
package norm_pkg;

    localparam int NORM_COL   = 8;
    localparam int NORM_W_OUT = 16;
    localparam int NORM_ROWS  = 16;
    localparam int NORM_DEPTH = 2;
    localparam int NORM_AW    = $clog2(NORM_ROWS);

    typedef logic [NORM_COL-1:0][NORM_W_OUT-1:0] row_t;

    typedef struct packed {
        row_t               r1;
        row_t               r2;
        logic [NORM_AW-1:0] addr;
    } row_pair_t;

endpackage

// File: rtl/norm_row_packer_row_fifo.sv
// Small synchronous FIFO with a registered head word.
// A write into a full FIFO is taken only when a read happens in the same cycle.
module row_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_accept_o,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty, full, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign pop        = rd_en_i && !empty;
    assign push       = wr_en_i && (!full || pop);
    assign rd_ptr_inc = ptr_inc(rd_ptr_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = rd_ptr_inc;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // The head register bypasses storage when the incoming word becomes the new head.
        if (push && (empty || (pop && count_q == CW'(1))))
            head_d = wr_data_i;
        else if (pop && count_q > CW'(1))
            head_d = mem[rd_ptr_inc];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data_i;
    end

    assign wr_accept_o = !full || pop;
    assign rd_valid_o  = !empty;
    assign rd_data_o   = head_q;

endmodule

// File: rtl/norm_row_packer.sv
// Reassembles two serial normalized element streams into COL-wide rows and
// queues completed row pairs, tagged with a wrapping row address.
module norm_row_packer
    import norm_pkg::*;
#(
    parameter int COL   = NORM_COL,
    parameter int W_OUT = NORM_W_OUT,
    parameter int ROWS  = NORM_ROWS,
    parameter int DEPTH = NORM_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     norm_valid,
    input  logic [W_OUT-1:0]         psum_norm_1,
    input  logic [W_OUT-1:0]         psum_norm_2,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [COL*W_OUT-1:0]     m_row_1,
    output logic [COL*W_OUT-1:0]     m_row_2,
    output logic [$clog2(ROWS)-1:0]  m_addr,
    output logic                     overflow
);

    localparam int IW = $clog2(COL);
    localparam int AW = $clog2(ROWS);
    localparam int RW = COL * W_OUT;
    localparam int PW = 2 * RW + AW;
    localparam logic [IW-1:0] IDX_LAST = IW'(COL - 1);

    logic [IW-1:0]                 idx_q, idx_d;
    logic [AW-1:0]                 wr_row_q, wr_row_d;
    logic                          overflow_q, overflow_d;
    logic [COL-2:0][W_OUT-1:0]     asm1_q, asm2_q;
    logic [COL-1:0][W_OUT-1:0]     row1_w, row2_w;
    logic                          complete, accept;
    logic [PW-1:0]                 head_w;

    assign complete = norm_valid && (idx_q == IDX_LAST);

    // The last slot is never stored: it comes straight from the inputs on the completion cycle.
    for (genvar gi = 0; gi < COL; gi++) begin : g_slot
        if (gi < COL - 1) begin : g_stored
            always_ff @(posedge clk) begin
                if (norm_valid && idx_q == IW'(gi)) begin
                    asm1_q[gi] <= psum_norm_1;
                    asm2_q[gi] <= psum_norm_2;
                end
            end
            assign row1_w[gi] = asm1_q[gi];
            assign row2_w[gi] = asm2_q[gi];
        end else begin : g_live
            assign row1_w[gi] = psum_norm_1;
            assign row2_w[gi] = psum_norm_2;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        wr_row_d   = wr_row_q;
        overflow_d = overflow_q;
        if (norm_valid) idx_d = idx_q + 1'b1;
        if (complete) begin
            if (accept) wr_row_d   = wr_row_q + 1'b1;
            else        overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            wr_row_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            wr_row_q   <= wr_row_d;
            overflow_q <= overflow_d;
        end
    end

    row_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_row_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (complete),
        .wr_data_i   ({row1_w, row2_w, wr_row_q}),
        .wr_accept_o (accept),
        .rd_en_i     (m_ready),
        .rd_valid_o  (m_valid),
        .rd_data_o   (head_w)
    );

    assign {m_row_1, m_row_2, m_addr} = head_w;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_norm_row_packer.sv
// Bench for norm_row_packer: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_norm_row_packer;
    import norm_pkg::*;

    localparam int COL   = NORM_COL;
    localparam int W     = NORM_W_OUT;
    localparam int ROWS  = NORM_ROWS;
    localparam int DEPTH = NORM_DEPTH;
    localparam int AW    = $clog2(ROWS);
    localparam int RW    = COL * W;

    logic          clk;
    logic          reset;
    logic          norm_valid;
    logic [W-1:0]  psum_norm_1, psum_norm_2;
    logic          m_valid, m_ready;
    logic [RW-1:0] m_row_1, m_row_2;
    logic [AW-1:0] m_addr;
    logic          overflow;

    norm_row_packer #(.COL(COL), .W_OUT(W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .norm_valid  (norm_valid),
        .psum_norm_1 (psum_norm_1),
        .psum_norm_2 (psum_norm_2),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_row_1     (m_row_1),
        .m_row_2     (m_row_2),
        .m_addr      (m_addr),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] r1;
        logic [RW-1:0] r2;
        int            addr;
    } exp_t;

    exp_t          mq[$];
    logic [RW-1:0] m_cur1, m_cur2;
    int            m_cnt;
    int            m_next_addr;
    logic          m_ovf;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, advance the reference model, compare outputs.
    task automatic step(input logic rst, input logic nv, input logic [W-1:0] e1,
                        input logic [W-1:0] e2, input logic rdy);
        logic done;
        logic pop;
        exp_t e;
        reset       = rst;
        norm_valid  = nv;
        psum_norm_1 = e1;
        psum_norm_2 = e2;
        m_ready     = rdy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cnt       = 0;
            m_next_addr = 0;
            m_ovf       = 1'b0;
        end else begin
            done = 1'b0;
            pop  = (mq.size() > 0) && rdy;
            if (nv) begin
                m_cur1[m_cnt*W +: W] = e1;
                m_cur2[m_cnt*W +: W] = e2;
                if (m_cnt == COL - 1) begin
                    done  = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (pop) e = mq.pop_front();
            if (done) begin
                if (mq.size() < DEPTH) begin
                    e.r1 = m_cur1;
                    e.r2 = m_cur2;
                    e.addr = m_next_addr;
                    mq.push_back(e);
                    m_next_addr = (m_next_addr + 1) % ROWS;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        #1;
        check_val("m_valid", RW'(m_valid), RW'(mq.size() != 0));
        check_val("overflow", RW'(overflow), RW'(m_ovf));
        if (mq.size() != 0) begin
            check_val("m_row_1", m_row_1, mq[0].r1);
            check_val("m_row_2", m_row_2, mq[0].r2);
            check_val("m_addr", RW'(m_addr), RW'(mq[0].addr));
        end
    endtask

    // rdy_mode: 0 = ready low, 1 = ready high, 2 = ready only on the last element.
    task automatic send_row(input int b1, input int b2, input int rdy_mode);
        for (int k = 0; k < COL; k++) begin
            logic rdy;
            rdy = (rdy_mode == 1) || (rdy_mode == 2 && k == COL - 1);
            step(1'b0, 1'b1, W'(b1 + k), W'(b2 + k), rdy);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, W'($urandom), W'($urandom), rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [9:0] gap_pat;
        int         v;
        m_cur1 = '0;
        m_cur2 = '0;

        do_reset();
        check_val("reset_row_1", m_row_1, '0);
        check_val("reset_row_2", m_row_2, '0);
        check_val("reset_addr", RW'(m_addr), '0);
        check_val("reset_valid", RW'(m_valid), '0);

        // Single row with the consumer ready.
        send_row(1, 101, 1);
        check_val("single_valid", RW'(m_valid), RW'(1));
        check_val("single_row_1", m_row_1, RW'(128'h0008_0007_0006_0005_0004_0003_0002_0001));
        idle(2, 1'b1);

        // Gapped input 1,1,0,0,1x6 carrying 1..8.
        do_reset();
        gap_pat = 10'b1111110011;
        v = 1;
        for (int k = 0; k < 10; k++) begin
            if (gap_pat[k]) begin
                step(1'b0, 1'b1, W'(v), W'(100 + v), 1'b1);
                v++;
            end else begin
                step(1'b0, 1'b0, W'($urandom), W'($urandom), 1'b1);
            end
        end
        check_val("gap_row_2", m_row_2, RW'(128'h006c_006b_006a_0069_0068_0067_0066_0065));
        idle(2, 1'b1);

        // Back-pressure: three rows into a two-deep FIFO.
        do_reset();
        send_row(10, 20, 0);
        send_row(30, 40, 0);
        send_row(50, 60, 0);
        check_val("bp_overflow", RW'(overflow), RW'(1));
        idle(3, 1'b1);
        send_row(70, 80, 1);
        check_val("bp_next_addr", RW'(m_addr), RW'(2));
        idle(2, 1'b1);

        // Full FIFO with a pop on the completion cycle of the next row.
        do_reset();
        send_row(1, 2, 0);
        send_row(3, 4, 0);
        send_row(5, 6, 2);
        check_val("fullpop_overflow", RW'(overflow), '0);
        idle(4, 1'b1);

        // Address wrap across ROWS.
        do_reset();
        for (int r = 0; r < ROWS + 3; r++) send_row(r * 16, r * 16 + 1000, 1);
        idle(2, 1'b1);

        // Reset in the middle of a row.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, W'(200 + k), W'(300 + k), 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b1);
        check_val("midreset_valid", RW'(m_valid), '0);
        send_row(11, 211, 1);
        check_val("midreset_addr", RW'(m_addr), '0);
        check_val("midreset_row_1", m_row_1, RW'(128'h0012_0011_0010_000f_000e_000d_000c_000b));
        idle(2, 1'b1);

        // Random traffic with random back-pressure and rare resets.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 W'($urandom), W'($urandom), $urandom_range(0, 1) == 1);
        end
        idle(4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
